inventory_access_scheduler: RTL and testbench

- Arbitrates the inventory block's single shared stock-index port between two requesters.
- Requester 1: execute-order events from the order-book/ITCH parser, which are writes.
- Requester 2: normalised-inventory lookups from the quote/price-estimation engine, which are reads.
- Buffers execute events in a small FIFO and grants exactly one access per cycle: read priority, with a starvation guard and a full-FIFO override. Drives the inventory's stock index, execute strobe, quantity and side.

---
 rtl/inventory_access_scheduler.sv | 153 +++++++++++++++
 tb/tb_inventory_access_scheduler.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inventory_access_scheduler.sv
// Shares the inventory block's single stock-index port between buffered execute-order
// writes and normalised-inventory reads: read priority with a starvation guard and full-FIFO override.
module inventory_access_scheduler #(
    parameter int unsigned NUM_STOCKS   = 4,
    parameter int unsigned FP_WORD_SIZE = 64,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                                   i_clk,
    input  logic                                   i_reset_n,
    input  logic                                   i_exec_valid,
    output logic                                   o_exec_ready,
    input  logic [$clog2(NUM_STOCKS)-1:0]          i_exec_stock_id,
    input  logic [15:0]                            i_exec_quantity,
    input  logic                                   i_exec_side,
    input  logic                                   i_rd_valid,
    output logic                                   o_rd_ready,
    input  logic [$clog2(NUM_STOCKS)-1:0]          i_rd_stock_id,
    output logic                                   o_rd_valid,
    output logic [$clog2(NUM_STOCKS)-1:0]          o_rd_stock_id,
    output logic signed [FP_WORD_SIZE-1:0]         o_rd_norm_inventory,
    output logic [$clog2(NUM_STOCKS)-1:0]          o_inv_stock_id,
    output logic                                   o_inv_execute_order,
    output logic [15:0]                            o_inv_execute_order_quantity,
    output logic                                   o_inv_execute_order_side,
    input  logic signed [FP_WORD_SIZE-1:0]         i_inv_norm_inventory,
    output logic [$clog2(FIFO_DEPTH):0]            o_fifo_count
);

    localparam int unsigned STOCK_W  = $clog2(NUM_STOCKS);
    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned QTY_W    = 16;

    typedef struct packed {
        logic [STOCK_W-1:0] stock_id;
        logic [QTY_W-1:0]   quantity;
        logic               side;
    } exec_entry_t;

    exec_entry_t                     mem_q [FIFO_DEPTH];
    exec_entry_t                     mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]                wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]                rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]                count_q, count_d;
    logic [STARVE_W-1:0]             starve_q, starve_d;
    logic                            rd_valid_q, rd_valid_d;
    logic [STOCK_W-1:0]              rd_stock_id_q, rd_stock_id_d;
    logic signed [FP_WORD_SIZE-1:0]  rd_data_q, rd_data_d;

    logic        fifo_empty;
    logic        fifo_full;
    logic        starved;
    logic        write_grant;
    logic        read_grant;
    logic        exec_ready;
    logic        push;
    exec_entry_t head;
    exec_entry_t incoming;

    // Grant decision: reads win unless the FIFO is full or the writer has waited too long.
    always_comb begin
        fifo_empty  = (count_q == '0);
        fifo_full   = (count_q == CNT_W'(FIFO_DEPTH));
        starved     = (starve_q == STARVE_W'(STARVE_LIMIT));
        write_grant = i_reset_n & ~fifo_empty & (~i_rd_valid | fifo_full | starved);
        read_grant  = i_reset_n & i_rd_valid & ~write_grant;
        exec_ready  = i_reset_n & (~fifo_full | write_grant);
        push        = i_exec_valid & exec_ready;
        head        = mem_q[rd_ptr_q];
        incoming    = '{stock_id: i_exec_stock_id, quantity: i_exec_quantity, side: i_exec_side};
    end

    // FIFO bookkeeping; pointers wrap naturally since the depth is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = incoming;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (write_grant) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, write_grant})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Counts reads that bypassed a waiting write; any write or an empty FIFO clears it.
    always_comb begin
        starve_d = starve_q;
        if (write_grant || fifo_empty) begin
            starve_d = '0;
        end else if (read_grant && !starved) begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    always_comb begin
        rd_valid_d    = read_grant;
        rd_stock_id_d = rd_stock_id_q;
        rd_data_d     = rd_data_q;
        if (read_grant) begin
            rd_stock_id_d = i_rd_stock_id;
            rd_data_d     = i_inv_norm_inventory;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            starve_q      <= '0;
            rd_valid_q    <= 1'b0;
            rd_stock_id_q <= '0;
            rd_data_q     <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            starve_q      <= starve_d;
            rd_valid_q    <= rd_valid_d;
            rd_stock_id_q <= rd_stock_id_d;
            rd_data_q     <= rd_data_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        o_exec_ready                 = exec_ready;
        o_rd_ready                   = read_grant;
        o_rd_valid                   = rd_valid_q;
        o_rd_stock_id                = rd_stock_id_q;
        o_rd_norm_inventory          = rd_data_q;
        o_fifo_count                 = count_q;
        o_inv_execute_order          = write_grant;
        o_inv_stock_id               = write_grant ? head.stock_id : i_rd_stock_id;
        o_inv_execute_order_quantity = write_grant ? head.quantity : '0;
        o_inv_execute_order_side     = write_grant ? head.side : 1'b0;
    end

endmodule

// File: tb/tb_inventory_access_scheduler.sv
// Scoreboard bench for inventory_access_scheduler with a behavioural inventory
// (position times per-stock reciprocal) closing the loop on the shared port.
module tb_inventory_access_scheduler;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] qty;
        logic        side;
    } wr_t;

    typedef struct packed {
        logic [1:0]  id;
        logic [63:0] data;
    } rd_t;

    logic               i_clk = 1'b0;
    logic               i_reset_n;
    logic               i_exec_valid;
    logic               o_exec_ready;
    logic [1:0]         i_exec_stock_id;
    logic [15:0]        i_exec_quantity;
    logic               i_exec_side;
    logic               i_rd_valid;
    logic               o_rd_ready;
    logic [1:0]         i_rd_stock_id;
    logic               o_rd_valid;
    logic [1:0]         o_rd_stock_id;
    logic signed [63:0] o_rd_norm_inventory;
    logic [1:0]         o_inv_stock_id;
    logic               o_inv_execute_order;
    logic [15:0]        o_inv_execute_order_quantity;
    logic               o_inv_execute_order_side;
    logic signed [63:0] i_inv_norm_inventory;
    logic [3:0]         o_fifo_count;

    int n_checks = 0;
    int n_errors = 0;

    wr_t exp_wr [$];
    rd_t exp_rd [$];

    logic [63:0] rd_exp;
    logic        last_wr, last_rdy, last_push;
    int          last_cnt;
    logic        saw_full;

    longint pos [4] = '{default: 0};

    inventory_access_scheduler dut (
        .i_clk                        (i_clk),
        .i_reset_n                    (i_reset_n),
        .i_exec_valid                 (i_exec_valid),
        .o_exec_ready                 (o_exec_ready),
        .i_exec_stock_id              (i_exec_stock_id),
        .i_exec_quantity              (i_exec_quantity),
        .i_exec_side                  (i_exec_side),
        .i_rd_valid                   (i_rd_valid),
        .o_rd_ready                   (o_rd_ready),
        .i_rd_stock_id                (i_rd_stock_id),
        .o_rd_valid                   (o_rd_valid),
        .o_rd_stock_id                (o_rd_stock_id),
        .o_rd_norm_inventory          (o_rd_norm_inventory),
        .o_inv_stock_id               (o_inv_stock_id),
        .o_inv_execute_order          (o_inv_execute_order),
        .o_inv_execute_order_quantity (o_inv_execute_order_quantity),
        .o_inv_execute_order_side     (o_inv_execute_order_side),
        .i_inv_norm_inventory         (i_inv_norm_inventory),
        .o_fifo_count                 (o_fifo_count)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic signed [63:0] recip_of(input logic [1:0] id);
        return (id == 2'd1) ? 64'sh0000_0000_8000_0000 : 64'sh0000_0000_0100_0000;
    endfunction

    // Inventory model: combinational read, position updated on the write edge.
    always_comb i_inv_norm_inventory = 64'(pos[o_inv_stock_id] * recip_of(o_inv_stock_id));

    always @(posedge i_clk) begin
        if (o_inv_execute_order) begin
            if (o_inv_execute_order_side)
                pos[o_inv_stock_id] <= pos[o_inv_stock_id] - longint'(o_inv_execute_order_quantity);
            else
                pos[o_inv_stock_id] <= pos[o_inv_stock_id] + longint'(o_inv_execute_order_quantity);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // Monitor: every presented write or read-return is matched against the scoreboard.
    always @(negedge i_clk) begin
        if (o_inv_execute_order === 1'b1) begin
            if (exp_wr.size() == 0) begin
                fail_now("wr_unexpected");
            end else begin
                wr_t e;
                e = exp_wr.pop_front();
                chk("wr_stock", 64'(o_inv_stock_id), 64'(e.id));
                chk("wr_qty", 64'(o_inv_execute_order_quantity), 64'(e.qty));
                chk("wr_side", 64'(o_inv_execute_order_side), 64'(e.side));
            end
        end
        if (o_rd_valid === 1'b1) begin
            if (exp_rd.size() == 0) begin
                fail_now("rd_unexpected");
            end else begin
                rd_t r;
                r = exp_rd.pop_front();
                chk("rd_stock", 64'(o_rd_stock_id), 64'(r.id));
                chk("rd_data", o_rd_norm_inventory, r.data);
            end
        end
    end

    // Sample handshakes mid-cycle and record what the DUT accepted.
    task automatic sample();
        @(negedge i_clk);
        last_wr   = o_inv_execute_order;
        last_rdy  = o_rd_ready;
        last_cnt  = int'(o_fifo_count);
        last_push = i_exec_valid & o_exec_ready;
        if (o_rd_ready) exp_rd.push_back('{id: i_rd_stock_id, data: rd_exp});
        if (last_push) exp_wr.push_back('{id: i_exec_stock_id, qty: i_exec_quantity, side: i_exec_side});
    endtask

    task automatic advance();
        @(posedge i_clk);
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic full_rules();
        chk("count_le_depth", 64'(last_cnt <= 8), 64'd1);
        if (last_cnt == 8) begin
            saw_full = 1'b1;
            chk("full_write_grant", 64'(last_wr), 64'd1);
            chk("full_no_read", 64'(last_rdy), 64'd0);
            chk("full_push_ok", 64'(o_exec_ready), 64'd1);
        end
    endtask

    task automatic send_exec(input logic [1:0] id, input logic [15:0] qty, input logic side,
                             input logic fill_mode);
        logic acc;
        acc = 1'b0;
        i_exec_valid    = 1'b1;
        i_exec_stock_id = id;
        i_exec_quantity = qty;
        i_exec_side     = side;
        for (int t = 0; t < 20 && !acc; t++) begin
            sample();
            if (fill_mode) full_rules();
            acc = last_push;
            advance();
        end
        if (!acc) fail_now("exec_accept_timeout");
        i_exec_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  grants [7];
        int  exp_g  [7];
        logic found;

        exp_g = '{1, 1, 1, 1, 2, 1, 1};
        saw_full        = 1'b0;
        rd_exp          = '0;
        i_reset_n       = 1'b0;
        i_exec_valid    = 1'b1;
        i_exec_stock_id = 2'd1;
        i_exec_quantity = 16'd7;
        i_exec_side     = 1'b0;
        i_rd_valid      = 1'b1;
        i_rd_stock_id   = 2'd0;
        #1;

        // Reset with requests offered: nothing may be granted.
        step();
        step();
        sample();
        chk("rst_exec_ready", 64'(o_exec_ready), 64'd0);
        chk("rst_rd_ready", 64'(o_rd_ready), 64'd0);
        chk("rst_inv_exec", 64'(o_inv_execute_order), 64'd0);
        chk("rst_rd_valid", 64'(o_rd_valid), 64'd0);
        chk("rst_fifo_count", 64'(o_fifo_count), 64'd0);
        advance();
        i_reset_n    = 1'b1;
        i_exec_valid = 1'b0;
        i_rd_valid   = 1'b0;

        sample();
        chk("idle_exec_ready", 64'(o_exec_ready), 64'd1);
        chk("idle_rd_valid", 64'(o_rd_valid), 64'd0);
        chk("idle_rd_stock", 64'(o_rd_stock_id), 64'd0);
        chk("idle_rd_data", o_rd_norm_inventory, 64'd0);
        chk("idle_inv_exec", 64'(o_inv_execute_order), 64'd0);
        chk("idle_fifo_count", 64'(o_fifo_count), 64'd0);
        advance();

        // Single execute event reaches the inventory one cycle after acceptance.
        send_exec(2'd2, 16'd50, 1'b0, 1'b0);
        sample();
        chk("t1_count_one", 64'(o_fifo_count), 64'd1);
        chk("t1_strobe", 64'(o_inv_execute_order), 64'd1);
        chk("t1_inv_stock", 64'(o_inv_stock_id), 64'd2);
        advance();
        sample();
        chk("t1_count_zero", 64'(o_fifo_count), 64'd0);
        advance();

        // Reads: stock 1 holds +1 share at 0.5, stock 2 holds +50 at 1/256.
        send_exec(2'd1, 16'd1, 1'b0, 1'b0);
        step();
        step();
        i_rd_valid    = 1'b1;
        i_rd_stock_id = 2'd1;
        rd_exp        = 64'h0000_0000_8000_0000;
        sample();
        chk("t2_rd_ready", 64'(o_rd_ready), 64'd1);
        advance();
        i_rd_stock_id = 2'd2;
        rd_exp        = 64'h0000_0000_3200_0000;
        sample();
        chk("t2_rd_ready_b", 64'(o_rd_ready), 64'd1);
        advance();
        i_rd_valid = 1'b0;
        step();
        step();

        // Starvation guard: four bypassing reads, then one write, then reads again.
        i_rd_valid      = 1'b1;
        i_rd_stock_id   = 2'd3;
        rd_exp          = '0;
        send_exec(2'd0, 16'd5, 1'b1, 1'b0);
        for (int k = 0; k < 7; k++) begin
            sample();
            grants[k] = last_rdy ? 1 : (last_wr ? 2 : 0);
            advance();
        end
        for (int k = 0; k < 7; k++) chk($sformatf("t3_grant%0d", k), 64'(grants[k]), 64'(exp_g[k]));
        i_rd_valid = 1'b0;
        step();
        step();

        // Fill under continuous reads; full forces writes and pushes only ride on pops.
        i_rd_valid    = 1'b1;
        i_rd_stock_id = 2'd3;
        rd_exp        = '0;
        for (int i = 0; i < 12; i++) send_exec(2'(i % 3), 16'(100 + i), 1'(i % 2), 1'b1);
        found = 1'b0;
        for (int t = 0; t < 100 && !found; t++) begin
            sample();
            full_rules();
            found = (last_cnt == 0);
            advance();
        end
        chk("t4_reached_full", 64'(saw_full), 64'd1);
        chk("t4_drained", 64'(found), 64'd1);
        i_rd_valid = 1'b0;
        step();
        step();

        // Ordered same-stock writes, then read-after-write: +100 - 356 = -256 -> -1.0.
        send_exec(2'd3, 16'd100, 1'b0, 1'b0);
        send_exec(2'd3, 16'd356, 1'b1, 1'b0);
        found = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
            sample();
            found = last_wr && (last_cnt == 1);
            advance();
        end
        chk("t5_last_write_seen", 64'(found), 64'd1);
        i_rd_valid    = 1'b1;
        i_rd_stock_id = 2'd3;
        rd_exp        = 64'hFFFF_FFFF_0000_0000;
        sample();
        chk("t5_rd_ready", 64'(o_rd_ready), 64'd1);
        advance();
        i_rd_valid = 1'b0;
        step();
        step();

        // Reset with three events queued behind reads: all are discarded.
        i_rd_valid    = 1'b1;
        i_rd_stock_id = 2'd3;
        rd_exp        = 64'hFFFF_FFFF_0000_0000;
        send_exec(2'd0, 16'd11, 1'b0, 1'b0);
        send_exec(2'd0, 16'd12, 1'b0, 1'b0);
        send_exec(2'd0, 16'd13, 1'b0, 1'b0);
        sample();
        chk("t6_queued", 64'(o_fifo_count), 64'd3);
        advance();
        i_reset_n  = 1'b0;
        i_rd_valid = 1'b0;
        exp_wr.delete();
        sample();
        chk("t6_rst_strobe", 64'(o_inv_execute_order), 64'd0);
        chk("t6_rst_ready", 64'(o_exec_ready), 64'd0);
        advance();
        i_reset_n = 1'b1;
        for (int t = 0; t < 8; t++) begin
            sample();
            chk("t6_no_strobe", 64'(o_inv_execute_order), 64'd0);
            chk("t6_count_zero", 64'(o_fifo_count), 64'd0);
            advance();
        end

        step();
        chk("end_wr_queue_empty", 64'(exp_wr.size()), 64'd0);
        chk("end_rd_queue_empty", 64'(exp_rd.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
